// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int         PIPE_REG_AW = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [PIPE_REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_REG_AW-1:0] rs;
    logic [PIPE_REG_AW-1:0] rt;
    logic                   uses_rs;
    logic                   uses_rt;
    logic [PIPE_REG_AW-1:0] dest;
    logic                   reg_write;
    logic                   mem_read;
  } stage_rec_t;

  // MEM outranks WB; a load sitting in MEM has no data yet and never forwards.
  function automatic logic [1:0] fwd_sel(
    input stage_rec_t             mem_rec,
    input stage_rec_t             wb_rec,
    input logic [PIPE_REG_AW-1:0] src,
    input logic                   src_used
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src_used && (src != REG_ZERO)) begin
      if (wb_rec.valid && wb_rec.reg_write && (wb_rec.dest == src))
        sel = FWD_WB;
      if (mem_rec.valid && mem_rec.reg_write && !mem_rec.mem_read && (mem_rec.dest == src))
        sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Saturating up-counter, cleared only by synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable && (r_count != C_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Load-use stall, branch flush and EX forwarding control for a
//               5-stage MIPS pipeline, plus stall/flush statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_rec_t r_ex;
  stage_rec_t r_mem;
  stage_rec_t r_wb;
  stage_rec_t w_id_rec;

  logic [PIPE_REG_AW-1:0] w_id_rs;
  logic [PIPE_REG_AW-1:0] w_id_rt;
  logic                   w_rs_hit;
  logic                   w_rt_hit;
  logic                   w_load_use;
  logic                   w_flush;
  logic                   w_stall_issue;
  logic                   w_flush_issue;

  assign w_id_rs = PIPE_REG_AW'(id_rs);
  assign w_id_rt = PIPE_REG_AW'(id_rt);

  always_comb begin
    w_id_rec           = '0;
    w_id_rec.valid     = id_valid;
    w_id_rec.rs        = w_id_rs;
    w_id_rec.rt        = w_id_rt;
    w_id_rec.uses_rs   = id_uses_rs;
    w_id_rec.uses_rt   = id_uses_rt;
    w_id_rec.dest      = PIPE_REG_AW'(id_dest);
    w_id_rec.reg_write = id_reg_write;
    w_id_rec.mem_read  = id_mem_read;
  end

  assign w_rs_hit   = id_uses_rs & (w_id_rs == r_ex.dest);
  assign w_rt_hit   = id_uses_rt & (w_id_rt == r_ex.dest);
  assign w_load_use = id_valid & r_ex.valid & r_ex.mem_read &
                      (r_ex.dest != REG_ZERO) & (w_rs_hit | w_rt_hit);
  assign w_flush    = ex_branch_taken & r_ex.valid;

  // A stall coinciding with a flush is swallowed: the flush squashes the consumer.
  assign w_stall_issue = w_load_use & ~w_flush & ~reset;
  assign w_flush_issue = w_flush & ~reset;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = fwd_sel(r_mem, r_wb, r_ex.rs, r_ex.uses_rs);
    fwd_b       = fwd_sel(r_mem, r_wb, r_ex.rt, r_ex.uses_rt);
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a       = FWD_NONE;
      fwd_b       = FWD_NONE;
    end else if (w_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Shadow of ID/EX, EX/MEM, MEM/WB; a bubble enters as an all-zero NOP record.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= idex_bubble ? '0 : w_id_rec;
    end
  end

  logic w_unused_wb;
  assign w_unused_wb = ^{r_wb.rs, r_wb.rt, r_wb.uses_rs, r_wb.uses_rt, r_wb.mem_read};

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (w_stall_issue),
    .count  (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (w_flush_issue),
    .count  (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and random checks of pipe_hazard_ctrl against an
//               in-bench pipeline model; a narrow-counter copy shows saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int SMALL_W   = 3;
  localparam int MAX_BIG   = 65535;
  localparam int MAX_SMALL = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic               s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
  logic [1:0]         s_fwd_a, s_fwd_b;
  logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(SMALL_W)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit valid;
    int rs, rt;
    bit urs, urt;
    int dest;
    bit rw, mr;
  } ins_t;

  ins_t pipe_q[3];   // 0 = in EX, 1 = in MEM, 2 = in WB
  int   m_stalls, m_flushes, ms_stalls, ms_flushes;

  function automatic ins_t nop_ins();
    ins_t n;
    n.valid = 0; n.rs = 0; n.rt = 0; n.urs = 0; n.urt = 0; n.dest = 0; n.rw = 0; n.mr = 0;
    return n;
  endfunction

  function automatic int fwd_exp(int src, bit used);
    if (!used || src == 0) return 0;
    if (pipe_q[1].valid && pipe_q[1].rw && !pipe_q[1].mr && pipe_q[1].dest == src) return 2;
    if (pipe_q[2].valid && pipe_q[2].rw && pipe_q[2].dest == src) return 1;
    return 0;
  endfunction

  function automatic int sat_inc(int v, int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  initial begin
    bit e_stall, e_flush, e_pcw, e_ifw, e_iff, e_bub;
    int e_fa, e_fb;
    ins_t nin;
    for (int k = 0; k < 3; k++) pipe_q[k] = nop_ins();
    m_stalls = 0; m_flushes = 0; ms_stalls = 0; ms_flushes = 0;
    forever begin
      @(negedge clk);
      e_stall = id_valid && pipe_q[0].valid && pipe_q[0].mr && pipe_q[0].dest != 0 &&
                ((id_uses_rs && int'(id_rs) == pipe_q[0].dest) ||
                 (id_uses_rt && int'(id_rt) == pipe_q[0].dest));
      e_flush = ex_branch_taken && pipe_q[0].valid;
      if (reset) begin
        e_pcw = 0; e_ifw = 0; e_iff = 1; e_bub = 1; e_fa = 0; e_fb = 0;
      end else begin
        e_iff = e_flush;
        e_bub = e_flush || e_stall;
        e_pcw = e_flush || !e_stall;
        e_ifw = e_pcw;
        e_fa  = fwd_exp(pipe_q[0].rs, pipe_q[0].urs);
        e_fb  = fwd_exp(pipe_q[0].rt, pipe_q[0].urt);
      end
      check("pc_write", pc_write, e_pcw);
      check("ifid_write", ifid_write, e_ifw);
      check("ifid_flush", ifid_flush, e_iff);
      check("idex_bubble", idex_bubble, e_bub);
      check("fwd_a", fwd_a, e_fa);
      check("fwd_b", fwd_b, e_fb);
      check("stall_cnt", stall_cnt, m_stalls);
      check("flush_cnt", flush_cnt, m_flushes);
      check("small_stall_cnt", s_stall_cnt, ms_stalls);
      check("small_flush_cnt", s_flush_cnt, ms_flushes);
      check("small_bubble", s_idex_bubble, e_bub);
      @(posedge clk);
      if (reset) begin
        for (int k = 0; k < 3; k++) pipe_q[k] = nop_ins();
        m_stalls = 0; m_flushes = 0; ms_stalls = 0; ms_flushes = 0;
      end else begin
        if (e_flush) begin
          m_flushes  = sat_inc(m_flushes, MAX_BIG);
          ms_flushes = sat_inc(ms_flushes, MAX_SMALL);
        end else if (e_stall) begin
          m_stalls  = sat_inc(m_stalls, MAX_BIG);
          ms_stalls = sat_inc(ms_stalls, MAX_SMALL);
        end
        pipe_q[2] = pipe_q[1];
        pipe_q[1] = pipe_q[0];
        if (e_bub) begin
          pipe_q[0] = nop_ins();
        end else begin
          nin.valid = id_valid; nin.rs = int'(id_rs); nin.rt = int'(id_rt);
          nin.urs = id_uses_rs; nin.urt = id_uses_rt; nin.dest = int'(id_dest);
          nin.rw = id_reg_write; nin.mr = id_mem_read;
          pipe_q[0] = nin;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit rw, input bit mr, input bit br);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = 5'(dest); id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
  endtask

  task automatic drive_nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_nop();
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    // reset state and first cycle after release
    mid();
    check("rst_pc_write", pc_write, 0);
    check("rst_ifid_flush", ifid_flush, 1);
    check("rst_idex_bubble", idex_bubble, 1);
    cyc();
    reset = 1'b0;
    mid();
    check("post_rst_pc_write", pc_write, 1);
    check("post_rst_ifid_write", ifid_write, 1);
    check("post_rst_bubble", idex_bubble, 0);
    check("post_rst_stall_cnt", stall_cnt, 0);
    cyc();

    // add $9,$8,$8 ; sub $10,$8,$9 -> MEM forward on B
    do_reset();
    drive(1, 8, 8, 1, 1, 9, 1, 0, 0); cyc();
    drive(1, 8, 9, 1, 1, 10, 1, 0, 0); mid();
    check("t1_no_stall", pc_write, 1); cyc();
    drive_nop(); mid();
    check("t1_fwd_a", fwd_a, 0);
    check("t1_fwd_b", fwd_b, 2); cyc();

    // add $9 ; nop ; or $11,$9,$10 -> WB forward on A
    do_reset();
    drive(1, 8, 8, 1, 1, 9, 1, 0, 0); cyc();
    drive_nop(); cyc();
    drive(1, 9, 10, 1, 1, 11, 1, 0, 0); cyc();
    drive_nop(); mid();
    check("t2_fwd_a", fwd_a, 1);
    check("t2_fwd_b", fwd_b, 0); cyc();

    // lw $11,4($16) ; add $12,$11,$8 -> one stall, then WB forward
    do_reset();
    drive(1, 16, 11, 1, 0, 11, 1, 1, 0); cyc();
    drive(1, 11, 8, 1, 1, 12, 1, 0, 0); mid();
    check("t3_pc_write", pc_write, 0);
    check("t3_ifid_write", ifid_write, 0);
    check("t3_bubble", idex_bubble, 1); cyc();
    mid();
    check("t3_stall_cnt", stall_cnt, 1);
    check("t3_released", pc_write, 1); cyc();
    drive_nop(); mid();
    check("t3_fwd_a", fwd_a, 1); cyc();

    // load-use coinciding with a taken branch -> flush wins, stall not counted
    do_reset();
    drive(1, 16, 11, 1, 0, 11, 1, 1, 0); cyc();
    drive(1, 11, 8, 1, 1, 12, 1, 0, 1); mid();
    check("t4_ifid_flush", ifid_flush, 1);
    check("t4_bubble", idex_bubble, 1);
    check("t4_pc_write", pc_write, 1); cyc();
    drive_nop(); mid();
    check("t4_flush_cnt", flush_cnt, 1);
    check("t4_stall_cnt", stall_cnt, 0); cyc();

    // register 0 never forwards or stalls
    do_reset();
    drive(1, 8, 8, 1, 1, 0, 1, 0, 0); cyc();
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0); cyc();
    drive_nop(); mid();
    check("t5_fwd_a", fwd_a, 0);
    check("t5_fwd_b", fwd_b, 0); cyc();
    drive(1, 16, 0, 1, 0, 0, 1, 1, 0); cyc();
    drive(1, 0, 0, 1, 1, 2, 1, 0, 0); mid();
    check("t5_no_stall", pc_write, 1);
    check("t5_no_bubble", idex_bubble, 0); cyc();

    // reset raised in the middle of a stall
    do_reset();
    drive(1, 16, 11, 1, 0, 11, 1, 1, 0); cyc();
    drive(1, 11, 8, 1, 1, 12, 1, 0, 0); mid();
    check("t6_stalling", pc_write, 0);
    reset = 1'b1; #1;
    check("t6_rst_pc_write", pc_write, 0);
    check("t6_rst_ifid_flush", ifid_flush, 1);
    check("t6_rst_bubble", idex_bubble, 1); cyc();
    reset = 1'b0;
    drive(1, 11, 11, 1, 1, 13, 1, 0, 0); mid();
    check("t6_no_stall", pc_write, 1);
    check("t6_stall_cnt", stall_cnt, 0); cyc();
    drive_nop(); mid();
    check("t6_fwd_a", fwd_a, 0); cyc();

    // saturation on the narrow copy
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 16, 5, 1, 0, 5, 1, 1, 0); cyc();
      drive(1, 5, 6, 1, 1, 7, 1, 0, 0); cyc();
      drive_nop(); cyc();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0); cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    end
    drive_nop(); mid();
    check("sat_small_stall", s_stall_cnt, 7);
    check("sat_big_stall", stall_cnt, 10);
    check("sat_small_flush", s_flush_cnt, 7);
    check("sat_big_flush", flush_cnt, 9); cyc();

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0);
      cyc();
    end
    reset = 1'b0;
    drive_nop();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
